// File: rtl/scaler_axis_cfggen_if.sv
//------------------------------------------------------------------------------
// Module  : scaler_axis_cfggen_if
// Brief   : Config-register side bundle for one scaler axis config generator.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface scaler_axis_cfggen_if #(
  parameter int IN_W   = 10,
  parameter int OUT_W  = 12,
  parameter int FRAC_W = 17
);
  logic [IN_W-1:0]   in_full_i;
  logic [OUT_W-1:0]  out_size_i;
  logic [OUT_W-1:0]  out_active_i;
  logic [IN_W-1:0]   pos_bias_i;
  logic              busy_o;
  logic              cfg_update_o;
  logic [FRAC_W:0]   interp_factor_o;
  logic [IN_W-1:0]   in_needed_o;
  logic [IN_W-1:0]   in_full_o;
  logic [IN_W-1:0]   pos_1st_o;
  logic [OUT_W-1:0]  out_size_o;

  modport master (
    output in_full_i, out_size_i, out_active_i, pos_bias_i,
    input  busy_o, cfg_update_o, interp_factor_o, in_needed_o,
           in_full_o, pos_1st_o, out_size_o
  );

  modport slave (
    input  in_full_i, out_size_i, out_active_i, pos_bias_i,
    output busy_o, cfg_update_o, interp_factor_o, in_needed_o,
           in_full_o, pos_1st_o, out_size_o
  );
endinterface

`default_nettype wire

// File: rtl/scaler_axis_cfggen.sv
//------------------------------------------------------------------------------
// Module  : scaler_axis_cfggen
// Brief   : Per-axis scaler step / source-window generator, atomic cfg update.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module scaler_axis_cfggen #(
  parameter int IN_W   = 10,
  parameter int OUT_W  = 12,
  parameter int FRAC_W = 17
) (
  input  logic                SYS_CLK,
  input  logic                SYS_RST,
  scaler_axis_cfggen_if.slave cfg
);

  localparam int c_QW     = FRAC_W + 1;
  localparam int c_INV_W  = c_QW + IN_W;
  localparam int c_FULL_W = c_INV_W + OUT_W;
  localparam int c_RAW_W  = IN_W + OUT_W + 1;
  localparam int c_CNT_W  = $clog2(c_QW);

  localparam logic [c_CNT_W-1:0] c_CNT_TOP = c_CNT_W'(FRAC_W);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_DIV  = 2'd1;
  localparam logic [1:0] c_MUL  = 2'd2;
  localparam logic [1:0] c_OUT  = 2'd3;

  logic [1:0]          r_state;
  logic [IN_W-1:0]     r_in_full_l,    r_in_full_ll;
  logic [OUT_W-1:0]    r_out_size_l,   r_out_size_ll;
  logic [OUT_W-1:0]    r_out_active_l, r_out_active_ll;
  logic [IN_W-1:0]     r_bias_l,       r_bias_ll;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [1:0]          r_mcnt;
  logic [OUT_W-1:0]    r_rem;
  logic [c_QW-1:0]     r_quo;
  logic [c_INV_W-1:0]  r_inv;
  logic [c_FULL_W-1:0] r_full;
  logic [IN_W-1:0]     r_need;
  logic [IN_W-1:0]     r_pos;
  logic                r_upd;
  logic [c_QW-1:0]     r_factor_o;
  logic [IN_W-1:0]     r_needed_o, r_full_o, r_pos_o;
  logic [OUT_W-1:0]    r_size_o;

  logic                  w_go;
  logic [OUT_W:0]        w_rem_sh;
  logic                  w_ge;
  logic [OUT_W:0]        w_rem_nx;
  logic [c_RAW_W-1:0]    w_raw;
  logic [IN_W-1:0]       w_need;
  logic [IN_W-1:0]       w_span;
  logic signed [IN_W+1:0] w_pos_s;
  logic [IN_W-1:0]       w_pos;

  // A new request is any change against the shadow copy with a non-zero divisor
  assign w_go = ((r_in_full_l != r_in_full_ll) || (r_out_size_l != r_out_size_ll) ||
                 (r_out_active_l != r_out_active_ll) || (r_bias_l != r_bias_ll)) &&
                (r_out_size_l != '0);

  // Dividend is 2^FRAC_W, so only the first shifted-in bit is a one
  assign w_rem_sh = {r_rem, (r_cnt == c_CNT_TOP)};
  assign w_ge     = (w_rem_sh >= {1'b0, r_out_size_ll});
  assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_out_size_ll}) : w_rem_sh;

  assign w_raw  = c_RAW_W'(r_full >> FRAC_W) + c_RAW_W'(r_full[FRAC_W-1]);
  assign w_need = (w_raw < c_RAW_W'(r_in_full_ll)) ? w_raw[IN_W-1:0] : r_in_full_ll;
  assign w_span = r_in_full_ll - w_need;
  assign w_pos_s = $signed({2'b00, w_span >> 1}) +
                   $signed({{2{r_bias_ll[IN_W-1]}}, r_bias_ll});
  assign w_pos  = w_pos_s[IN_W+1]                       ? '0     :
                  (w_pos_s > $signed({2'b00, w_span})) ? w_span : w_pos_s[IN_W-1:0];

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      r_state         <= c_IDLE;
      r_in_full_l     <= '0;
      r_out_size_l    <= '0;
      r_out_active_l  <= '0;
      r_bias_l        <= '0;
      r_in_full_ll    <= '0;
      r_out_size_ll   <= '0;
      r_out_active_ll <= '0;
      r_bias_ll       <= '0;
      r_cnt           <= '0;
      r_mcnt          <= '0;
      r_rem           <= '0;
      r_quo           <= '0;
      r_inv           <= '0;
      r_full          <= '0;
      r_need          <= '0;
      r_pos           <= '0;
      r_upd           <= 1'b0;
      r_factor_o      <= '0;
      r_needed_o      <= '0;
      r_full_o        <= '0;
      r_pos_o         <= '0;
      r_size_o        <= '0;
    end else begin
      r_in_full_l    <= cfg.in_full_i;
      r_out_size_l   <= cfg.out_size_i;
      r_out_active_l <= cfg.out_active_i;
      r_bias_l       <= cfg.pos_bias_i;
      r_upd          <= 1'b0;
      // OUT always completes; a change seen there is picked up from IDLE
      if (w_go && (r_state != c_OUT)) begin
        r_in_full_ll    <= r_in_full_l;
        r_out_size_ll   <= r_out_size_l;
        r_out_active_ll <= r_out_active_l;
        r_bias_ll       <= r_bias_l;
        r_cnt           <= c_CNT_TOP;
        r_rem           <= '0;
        r_quo           <= '0;
        r_state         <= c_DIV;
      end else begin
        case (r_state)
          c_DIV: begin
            r_rem <= w_rem_nx[OUT_W-1:0];
            r_quo <= {r_quo[c_QW-2:0], w_ge};
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
              r_mcnt  <= '0;
              r_state <= c_MUL;
            end
          end
          c_MUL: begin
            r_inv  <= c_INV_W'(r_quo) * c_INV_W'(r_in_full_ll);
            r_full <= c_FULL_W'(r_inv) * c_FULL_W'(r_out_active_ll);
            r_need <= w_need;
            r_pos  <= w_pos;
            r_mcnt <= r_mcnt + 1'b1;
            if (r_mcnt == 2'd2) r_state <= c_OUT;
          end
          c_OUT: begin
            r_factor_o <= r_quo;
            r_needed_o <= r_need;
            r_full_o   <= r_in_full_ll;
            r_pos_o    <= r_pos;
            r_size_o   <= r_out_size_ll;
            r_upd      <= 1'b1;
            r_state    <= c_IDLE;
          end
          default: r_state <= c_IDLE;
        endcase
      end
    end
  end

  assign cfg.busy_o          = (r_state != c_IDLE);
  assign cfg.cfg_update_o    = r_upd;
  assign cfg.interp_factor_o = r_factor_o;
  assign cfg.in_needed_o     = r_needed_o;
  assign cfg.in_full_o       = r_full_o;
  assign cfg.pos_1st_o       = r_pos_o;
  assign cfg.out_size_o      = r_size_o;

endmodule

`default_nettype wire

// File: tb/tb_scaler_axis_cfggen.sv
//------------------------------------------------------------------------------
// Module  : tb_scaler_axis_cfggen
// Brief   : Directed and random checks of scaler_axis_cfggen against a model.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_scaler_axis_cfggen;
  localparam int IN_W   = 10;
  localparam int OUT_W  = 12;
  localparam int FRAC_W = 17;
  localparam int LAT    = FRAC_W + 6;

  typedef struct {
    longint factor;
    longint need;
    longint pos;
    longint in_full;
    longint out_size;
  } cfg_t;

  logic SYS_CLK = 1'b0;
  logic SYS_RST = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  cfg_t cur;
  int   prev_in[4];

  scaler_axis_cfggen_if #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC_W(FRAC_W)) cfg_if ();

  scaler_axis_cfggen #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC_W(FRAC_W)) dut (
    .SYS_CLK (SYS_CLK),
    .SYS_RST (SYS_RST),
    .cfg     (cfg_if)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic straight from the scaling rules
  function automatic cfg_t model(input int in_full, input int out_size,
                                 input int out_active, input int bias);
    cfg_t   e;
    longint full, raw, span, p, sb;
    e.factor   = (longint'(1) << FRAC_W) / out_size;
    full       = e.factor * in_full * out_active;
    raw        = (full + (longint'(1) << (FRAC_W - 1))) / (longint'(1) << FRAC_W);
    e.need     = (raw < in_full) ? raw : in_full;
    span       = in_full - e.need;
    sb         = (bias >= (1 << (IN_W - 1))) ? bias - (1 << IN_W) : bias;
    p          = span / 2 + sb;
    e.pos      = (p < 0) ? 0 : ((p > span) ? span : p);
    e.in_full  = in_full;
    e.out_size = out_size;
    return e;
  endfunction

  function automatic bit outs_hold();
    return (cfg_if.interp_factor_o == cur.factor[FRAC_W:0]) &&
           (cfg_if.in_needed_o == cur.need[IN_W-1:0]) &&
           (cfg_if.pos_1st_o == cur.pos[IN_W-1:0]) &&
           (cfg_if.in_full_o == cur.in_full[IN_W-1:0]) &&
           (cfg_if.out_size_o == cur.out_size[OUT_W-1:0]);
  endfunction

  task automatic drive(input int in_full, input int out_size, input int out_active, input int bias);
    cfg_if.in_full_i    = IN_W'(in_full);
    cfg_if.out_size_i   = OUT_W'(out_size);
    cfg_if.out_active_i = OUT_W'(out_active);
    cfg_if.pos_bias_i   = IN_W'(bias);
    prev_in[0] = in_full;  prev_in[1] = out_size;
    prev_in[2] = out_active; prev_in[3] = bias;
  endtask

  task automatic cycle();
    @(posedge SYS_CLK);
    @(negedge SYS_CLK);
  endtask

  // Inputs are applied at this negedge; n counts posedges, n=1 captures into _L
  task automatic wait_cfg(input string tag, input int in_full, input int out_size,
                          input int out_active, input int bias);
    cfg_t e = model(in_full, out_size, out_active, bias);
    int lat = -1, pulses = 0, glitch = 0;
    logic busy_mid = 1'b0;
    for (int n = 1; n <= LAT + 40; n++) begin
      cycle();
      if (n == 3) busy_mid = cfg_if.busy_o;
      if (cfg_if.cfg_update_o) begin
        pulses++;
        if (lat < 0) lat = n - 1;
      end else if (lat < 0 && !outs_hold()) begin
        glitch++;
      end
      if (lat >= 0 && n >= lat + 4) break;
    end
    chk_eq({tag, "_latency"}, 64'(lat), 64'(LAT));
    chk_eq({tag, "_pulses"}, 64'(pulses), 64'd1);
    chk_eq({tag, "_hold"}, 64'(glitch), 64'd0);
    chk_eq({tag, "_busy_mid"}, 64'(busy_mid), 64'd1);
    chk_eq({tag, "_busy_end"}, 64'(cfg_if.busy_o), 64'd0);
    chk_eq({tag, "_factor"}, 64'(cfg_if.interp_factor_o), e.factor);
    chk_eq({tag, "_need"}, 64'(cfg_if.in_needed_o), e.need);
    chk_eq({tag, "_pos"}, 64'(cfg_if.pos_1st_o), e.pos);
    chk_eq({tag, "_in_full"}, 64'(cfg_if.in_full_o), e.in_full);
    chk_eq({tag, "_out_size"}, 64'(cfg_if.out_size_o), e.out_size);
    cur = e;
  endtask

  task automatic chk_zero(input string tag);
    chk_eq({tag, "_busy"}, 64'(cfg_if.busy_o), 64'd0);
    chk_eq({tag, "_upd"}, 64'(cfg_if.cfg_update_o), 64'd0);
    chk_eq({tag, "_factor"}, 64'(cfg_if.interp_factor_o), 64'd0);
    chk_eq({tag, "_need"}, 64'(cfg_if.in_needed_o), 64'd0);
    chk_eq({tag, "_in_full"}, 64'(cfg_if.in_full_o), 64'd0);
    chk_eq({tag, "_pos"}, 64'(cfg_if.pos_1st_o), 64'd0);
    chk_eq({tag, "_out_size"}, 64'(cfg_if.out_size_o), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, busy_hi, glitch, a, b, c, d;
    cur = '{0, 0, 0, 0, 0};
    drive(0, 0, 0, 0);
    SYS_RST = 1'b1;
    repeat (3) cycle();
    chk_zero("reset");
    SYS_RST = 1'b0;
    repeat (3) cycle();
    chk_eq("idle_after_reset", 64'(cfg_if.busy_o), 64'd0);

    drive(240, 960, 960, 0);       wait_cfg("t1", 240, 960, 960, 0);
    drive(240, 2160, 1920, 0);     wait_cfg("t2", 240, 2160, 1920, 0);
    drive(240, 2160, 1920, 20);    wait_cfg("t3p", 240, 2160, 1920, 20);
    drive(240, 2160, 1920, 'h3EC); wait_cfg("t3n", 240, 2160, 1920, 'h3EC);

    // Change mid-division: only the second request may produce a pulse
    drive(240, 960, 960, 0);
    pulses = 0;
    repeat (7) begin
      cycle();
      if (cfg_if.cfg_update_o) pulses++;
    end
    chk_eq("t4_no_early_pulse", 64'(pulses), 64'd0);
    drive(240, 2160, 1920, 0);     wait_cfg("t4", 240, 2160, 1920, 0);

    // Reset while the multiplier pipeline is running
    drive(240, 960, 960, 0);
    pulses = 0;
    repeat (21) begin
      cycle();
      if (cfg_if.cfg_update_o) pulses++;
    end
    chk_eq("t5_busy_in_mul", 64'(cfg_if.busy_o), 64'd1);
    chk_eq("t5_no_pulse", 64'(pulses), 64'd0);
    SYS_RST = 1'b1;
    cycle();
    chk_zero("t5_reset");
    SYS_RST = 1'b0;
    cur = '{0, 0, 0, 0, 0};
    wait_cfg("t5", 240, 960, 960, 0);

    // Zero divisor never starts anything, outputs keep the last config
    pulses = 0; busy_hi = 0; glitch = 0;
    for (int i = 0; i < 30; i++) begin
      drive($urandom_range(1, 1023), 0, $urandom_range(0, 4095), $urandom_range(0, 1023));
      cycle();
      if (cfg_if.cfg_update_o) pulses++;
      if (cfg_if.busy_o) busy_hi++;
      if (!outs_hold()) glitch++;
    end
    chk_eq("t6_pulses", 64'(pulses), 64'd0);
    chk_eq("t6_busy", 64'(busy_hi), 64'd0);
    chk_eq("t6_hold", 64'(glitch), 64'd0);

    drive(1023, 1, 4095, 0);       wait_cfg("max_scale", 1023, 1, 4095, 0);
    drive(480, 960, 0, 0);         wait_cfg("zero_active", 480, 960, 0, 0);
    drive(1023, 4095, 4095, 511);  wait_cfg("max_bias", 1023, 4095, 4095, 511);
    drive(640, 1280, 1000, 512);   wait_cfg("min_bias", 640, 1280, 1000, 512);

    for (int i = 0; i < 20; i++) begin
      do begin
        a = $urandom_range(1, 1023);
        b = $urandom_range(1, 4095);
        c = $urandom_range(0, 4095);
        d = $urandom_range(0, 1023);
      end while (a == prev_in[0] && b == prev_in[1] && c == prev_in[2] && d == prev_in[3]);
      drive(a, b, c, d);
      wait_cfg($sformatf("rnd%0d", i), a, b, c, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
